arcade_round_ctrl: RTL and testbench
====================================

ARCADE_ROUND_CTRL -- requirements
Module: arcade_round_ctrl

Interface
REQ-001 Parameter ROUNDS, default 8: rounds per game (1..15).
REQ-002 Parameter LIVES, default 3: misses allowed before game over (1..3).
REQ-003 Parameter TIMEOUT_CYCLES, default 50: answer window length in clk cycles (1..255).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  level; begins a game when sampled high in IDLE or OVER.
REQ-007 answer_valid  in  1  user answer strobe; accepted only while answer_ready=1.
REQ-008 answer  in  4  user's binary answer.
REQ-009 target  out  4  number the user must enter in binary; held stable from SHOW through JUDGE.
REQ-010 target_valid  out  1  high in SHOW and WAIT.
REQ-011 answer_ready  out  1  high in WAIT only.
REQ-012 hit  out  1  one-cycle pulse on a correct answer.
REQ-013 miss  out  1  one-cycle pulse on a wrong answer or timeout.
REQ-014 score  out  4  correct answers this game, saturating at 15.
REQ-015 lives  out  2  remaining lives.
REQ-016 game_over  out  1  high in OVER.
REQ-017 busy  out  1  high in every state except IDLE and OVER.

Function
REQ-018 FSM states: IDLE, GEN, SHOW, WAIT, JUDGE, OVER.
REQ-019 IDLE/OVER -> GEN when start=1; entering GEN from IDLE or OVER clears score, round count, sets lives=LIVES.
REQ-020 GEN: latch the LFSR value into target; next state SHOW (1 cycle).
REQ-021 SHOW: 1 cycle; next state WAIT; wait counter cleared.
REQ-022 WAIT: on answer_valid=1 latch answer and go JUDGE; otherwise increment wait counter.
REQ-023 JUDGE: 1 cycle; answer==target -> hit=1, score+1 (saturating); else miss=1, lives-1 (no underflow); round count +1.
REQ-024 After JUDGE: lives==0 or round count==ROUNDS -> OVER; else GEN.
REQ-025 hit/miss asserted during JUDGE cycle only; never both.
REQ-026 Latency: answer accepted on edge N yields hit/miss during cycle N+1 and next target in cycle N+2.
REQ-027 LFSR: 4-bit Fibonacci, x^4+x^3+1, next={q[2:0],q[3]^q[2]}, seed 4'b1001, free-running every cycle; never zero, so target in 1..15.
REQ-028 start ignored while busy; answer_valid ignored outside WAIT.
REQ-029 start held high in OVER restarts a new game immediately (OVER->GEN).

Reset
REQ-030 reset=0 asynchronously forces: state IDLE, LFSR 4'b1001, target 0, score 0, lives LIVES, round count 0, wait counter 0, all strobes/valids 0.
REQ-031 reset asserted mid-round abandons the round; no hit/miss is emitted.
REQ-032 Deassertion is synchronized externally; block leaves IDLE no earlier than first edge with start=1.

Configuration
REQ-033 Macro ARCADE_ROUND_TIMEOUT_EN defined: in WAIT, wait counter reaching TIMEOUT_CYCLES-1 without answer_valid -> JUDGE as a miss (answer ignored).
REQ-034 answer_valid in the same cycle as timeout expiry is accepted as a normal answer (answer wins).
REQ-035 Macro undefined: no timeout; WAIT lasts indefinitely; wait counter and TIMEOUT_CYCLES unused.

Structure
REQ-036 Shared package arcade_pkg holds the state enum, LFSR seed and polynomial constants, and the 4-bit number type.
REQ-037 One sub-module, arcade_lfsr4 (clk, reset, q[3:0]), instantiated once.

Verification
REQ-038 reset=0 for 3 cycles then 1, start=0 -> state IDLE, score=0, lives=LIVES, busy=0 indefinitely.
REQ-039 start pulse, then each round answer=target when answer_ready -> 8 hit pulses, score=8, lives=3, game_over=1 after 8th JUDGE.
REQ-040 Defaults, answer=~target every round -> 3 miss pulses, lives 3->2->1->0, game_over after round 3, score=0.
REQ-041 ARCADE_ROUND_TIMEOUT_EN, TIMEOUT_CYCLES=50, no answer -> miss pulse 50 cycles after WAIT entry; answer_valid on cycle 50 -> judged normally.
REQ-042 reset=0 while in WAIT with score=4 -> same-cycle return to IDLE, score=0, no hit/miss pulse.
REQ-043 start held high through a game -> OVER lasts one cycle, new game begins with score=0, lives=3.

Source files
------------

// File: rtl/arcade_pkg.sv
// ---------------------------------------------------------------------------
// arcade_pkg -- shared types and constants for the arcade round controller.
//   num_t      : 4-bit number shown to / entered by the player
//   state_e    : round controller FSM states
//   LFSR_SEED  : reset value of the target generator (never zero)
//   LFSR_TAPS  : feedback taps for x^4 + x^3 + 1 (feedback = q[3] ^ q[2])
//   lfsr_next(): one step of the 4-bit Fibonacci LFSR
// ---------------------------------------------------------------------------
package arcade_pkg;

  typedef logic [3:0] num_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN,
    ST_SHOW,
    ST_WAIT,
    ST_JUDGE,
    ST_OVER
  } state_e;

  localparam num_t LFSR_SEED = 4'b1001;
  localparam num_t LFSR_TAPS = 4'b1100;

  // Shift left, feed the XOR of the tapped bits into bit 0.
  function automatic num_t lfsr_next(input num_t q);
    return {q[2:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage : arcade_pkg

// File: rtl/arcade_lfsr4.sv
// ---------------------------------------------------------------------------
// arcade_lfsr4 -- free-running 4-bit Fibonacci LFSR (x^4 + x^3 + 1).
// Steps every clock; maximal length (15 states), so it never reaches zero.
// Ports:
//   clk    in  clock
//   reset  in  asynchronous active-low reset, loads LFSR_SEED
//   q      out current LFSR value
// ---------------------------------------------------------------------------
module arcade_lfsr4
  import arcade_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] q
);

  num_t q_q;
  num_t q_d;

  always_comb begin
    q_d = lfsr_next(q_q);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the simulator runs blocks in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= LFSR_SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : arcade_lfsr4

// File: rtl/arcade_round_ctrl.sv
// ---------------------------------------------------------------------------
// arcade_round_ctrl -- "type the number in binary" arcade game sequencer.
//
// Each round a pseudo-random target (1..15) is shown; the player answers
// once. A correct answer scores a point, a wrong one costs a life. The game
// ends when lives run out or ROUNDS rounds have been judged.
//
// Optional build macro: ARCADE_ROUND_TIMEOUT_EN -- when defined, an
// unanswered WAIT of TIMEOUT_CYCLES cycles is judged as a miss. When not
// defined, WAIT lasts until the player answers.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous active-low reset
//   start         in   level; starts a game from IDLE or OVER
//   answer_valid  in   answer strobe, accepted only while answer_ready
//   answer[3:0]   in   player's answer
//   target[3:0]   out  number to enter; stable from SHOW through JUDGE
//   target_valid  out  high in SHOW and WAIT
//   answer_ready  out  high in WAIT
//   hit / miss    out  one-cycle judgement pulses (JUDGE cycle)
//   score[3:0]    out  correct answers this game, saturating at 15
//   lives[1:0]    out  remaining lives
//   game_over     out  high in OVER
//   busy          out  high outside IDLE and OVER
// ---------------------------------------------------------------------------
module arcade_round_ctrl
  import arcade_pkg::*;
#(
  parameter int unsigned ROUNDS         = 8,
  parameter int unsigned LIVES          = 3,
  parameter int unsigned TIMEOUT_CYCLES = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       answer_valid,
  input  logic [3:0] answer,
  output logic [3:0] target,
  output logic       target_valid,
  output logic       answer_ready,
  output logic       hit,
  output logic       miss,
  output logic [3:0] score,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       busy
);

  // Reject out-of-range configurations at elaboration time.
  if (ROUNDS < 1 || ROUNDS > 15) begin : g_bad_rounds
    $error("arcade_round_ctrl: ROUNDS must be 1..15");
  end
  if (LIVES < 1 || LIVES > 3) begin : g_bad_lives
    $error("arcade_round_ctrl: LIVES must be 1..3");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("arcade_round_ctrl: TIMEOUT_CYCLES must be 1..255");
  end

  localparam logic [3:0] ROUNDS_W = 4'(ROUNDS);
  localparam logic [1:0] LIVES_W  = 2'(LIVES);

  // -------------------------------------------------------------------------
  // Target generator
  // -------------------------------------------------------------------------
  logic [3:0] lfsr_q;

  arcade_lfsr4 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e     state_q,        state_d;
  num_t       target_q,       target_d;
  logic [3:0] score_q,        score_d;
  logic [1:0] lives_q,        lives_d;
  logic [3:0] round_q,        round_d;
  logic       hit_q,          hit_d;
  logic       miss_q,         miss_d;
  logic       target_valid_q, target_valid_d;
  logic       answer_ready_q, answer_ready_d;
  logic       game_over_q,    game_over_d;
  logic       busy_q,         busy_d;

`ifdef ARCADE_ROUND_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt_q, wait_cnt_d;
`endif

  logic accept;
  logic timeout;
  logic judge;
  logic correct;

  always_comb begin
    accept = (state_q == ST_WAIT) && answer_valid;
`ifdef ARCADE_ROUND_TIMEOUT_EN
    // An answer in the expiry cycle wins over the timeout.
    timeout = (state_q == ST_WAIT) && !answer_valid && (wait_cnt_q == WAIT_LAST);
`else
    timeout = 1'b0;
`endif
    judge   = accept || timeout;
    // The judgement is made on the accepting edge so hit/miss, score and
    // lives are already registered during the JUDGE cycle; the answer
    // itself never needs to be stored.
    correct = accept && (answer == target_q);
  end

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    score_d  = score_q;
    lives_d  = lives_q;
    round_d  = round_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
`ifdef ARCADE_ROUND_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
`endif

    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d  = ST_GEN;
          score_d  = '0;
          round_d  = '0;
          lives_d  = LIVES_W;
          target_d = lfsr_q;
        end
      end
      ST_GEN: begin
        state_d = ST_SHOW;
      end
      ST_SHOW: begin
        state_d = ST_WAIT;
`ifdef ARCADE_ROUND_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        if (judge) begin
          state_d = ST_JUDGE;
          round_d = round_q + 4'd1;
          if (correct) begin
            hit_d   = 1'b1;
            score_d = (score_q == 4'hF) ? score_q : score_q + 4'd1;
          end else begin
            miss_d  = 1'b1;
            lives_d = (lives_q == 2'd0) ? lives_q : lives_q - 2'd1;
          end
        end else begin
`ifdef ARCADE_ROUND_TIMEOUT_EN
          wait_cnt_d = wait_cnt_q + 8'd1;
`endif
        end
      end
      ST_JUDGE: begin
        if (lives_q == 2'd0 || round_q == ROUNDS_W) begin
          state_d = ST_OVER;
        end else begin
          state_d  = ST_GEN;
          target_d = lfsr_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are decoded from the next state and registered, so they
    // line up exactly with the state they describe and never glitch.
    target_valid_d = (state_d == ST_SHOW) || (state_d == ST_WAIT);
    answer_ready_d = (state_d == ST_WAIT);
    game_over_d    = (state_d == ST_OVER);
    busy_d         = (state_d != ST_IDLE) && (state_d != ST_OVER);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      target_q       <= '0;
      score_q        <= '0;
      lives_q        <= LIVES_W;
      round_q        <= '0;
      hit_q          <= 1'b0;
      miss_q         <= 1'b0;
      target_valid_q <= 1'b0;
      answer_ready_q <= 1'b0;
      game_over_q    <= 1'b0;
      busy_q         <= 1'b0;
`ifdef ARCADE_ROUND_TIMEOUT_EN
      wait_cnt_q     <= '0;
`endif
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      score_q        <= score_d;
      lives_q        <= lives_d;
      round_q        <= round_d;
      hit_q          <= hit_d;
      miss_q         <= miss_d;
      target_valid_q <= target_valid_d;
      answer_ready_q <= answer_ready_d;
      game_over_q    <= game_over_d;
      busy_q         <= busy_d;
`ifdef ARCADE_ROUND_TIMEOUT_EN
      wait_cnt_q     <= wait_cnt_d;
`endif
    end
  end

  assign target       = target_q;
  assign target_valid = target_valid_q;
  assign answer_ready = answer_ready_q;
  assign hit          = hit_q;
  assign miss         = miss_q;
  assign score        = score_q;
  assign lives        = lives_q;
  assign game_over    = game_over_q;
  assign busy         = busy_q;

endmodule : arcade_round_ctrl

// File: tb/tb_arcade_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_arcade_round_ctrl -- scoreboard bench for arcade_round_ctrl (defaults:
// ROUNDS=8, LIVES=3, TIMEOUT_CYCLES=50). Stimulus pushes the expected
// judgement of every answered round; a monitor pops and compares on each
// hit/miss pulse and checks every new target against a reference LFSR.
// ---------------------------------------------------------------------------
module tb_arcade_round_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       answer_valid;
  logic [3:0] answer;
  logic [3:0] target;
  logic       target_valid;
  logic       answer_ready;
  logic       hit;
  logic       miss;
  logic [3:0] score;
  logic [1:0] lives;
  logic       game_over;
  logic       busy;

  arcade_round_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .answer_valid (answer_valid),
    .answer       (answer),
    .target       (target),
    .target_valid (target_valid),
    .answer_ready (answer_ready),
    .hit          (hit),
    .miss         (miss),
    .score        (score),
    .lives        (lives),
    .game_over    (game_over),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       hit;
    logic       miss;
    logic [3:0] score;
    logic [1:0] lives;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference LFSR: x^4 + x^3 + 1, next = {q[2:0], q[3]^q[2]}, seed 1001.
  // prev_m holds the value the DUT latches into target on the edge entering GEN.
  logic [3:0] lfsr_m, prev_m;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_m <= 4'b1001;
      prev_m <= 4'b1001;
    end else begin
      prev_m <= lfsr_m;
      lfsr_m <= {lfsr_m[2:0], lfsr_m[3] ^ lfsr_m[2]};
    end
  end

  // Monitor: GEN is the only busy cycle with no target_valid and no pulse.
  logic [3:0] gen_target = 4'd0;
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1) begin
      if (busy && !target_valid && !hit && !miss) begin
        check("gen_target", target, prev_m);
        gen_target = target;
      end
      if (hit || miss) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {hit, miss}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          check("hit",           hit,    e.hit);
          check("miss",          miss,   e.miss);
          check("score",         score,  e.score);
          check("lives",         lives,  e.lives);
          check("target_stable", target, gen_target);
        end
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (answer_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("ready_timeout", 16'd0, 16'd1);
  endtask

  // Answer one round (right or wrong) and queue the hand-computed result.
  task automatic play(input bit right, input logic [3:0] exp_score, input logic [1:0] exp_lives);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    check("target_valid", target_valid, 16'd1);
    answer       = right ? target : ~target;
    answer_valid = 1'b1;
    exp_q.push_back('{hit: right, miss: !right, score: exp_score, lives: exp_lives});
    @(negedge clk);
    answer_valid = 1'b0;
    answer       = 4'd0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge of the final JUDGE cycle.
  task automatic expect_over(input logic [3:0] exp_score);
    @(negedge clk);
    check("game_over", game_over, 16'd1);
    check("busy_over", busy, 16'd0);
    check("score_over", score, exp_score);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int k;
    reset        = 1'b0;
    start        = 1'b0;
    answer_valid = 1'b0;
    answer       = 4'd0;

    // Reset for three cycles, then idle with start low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_target", target, 16'd0);
    check("rst_lives",  lives,  16'd3);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_busy",  busy,      16'd0);
    check("idle_score", score,     16'd0);
    check("idle_lives", lives,     16'd3);
    check("idle_over",  game_over, 16'd0);
    check("idle_ready", answer_ready, 16'd0);

    // Game 1: all eight answers correct.
    start_pulse();
    for (int r = 1; r <= 8; r++) play(1'b1, 4'(r), 2'd3);
    expect_over(4'd8);
    check("g1_lives", lives, 16'd3);

    // Game 2: all answers wrong; three lives end it after round 3.
    start_pulse();
    play(1'b0, 4'd0, 2'd2);
    play(1'b0, 4'd0, 2'd1);
    play(1'b0, 4'd0, 2'd0);
    expect_over(4'd0);

    // Game 3: mixed; the round limit ends it with one life left.
    start_pulse();
    play(1'b1, 4'd1, 2'd3);
    play(1'b0, 4'd1, 2'd2);
    play(1'b1, 4'd2, 2'd2);
    play(1'b0, 4'd2, 2'd1);
    play(1'b1, 4'd3, 2'd1);
    play(1'b1, 4'd4, 2'd1);
    play(1'b1, 4'd5, 2'd1);
    play(1'b1, 4'd6, 2'd1);
    expect_over(4'd6);
    check("g3_lives", lives, 16'd1);

    // Game 4: long wait in WAIT.
    start_pulse();
    wait_ready(ok);
`ifdef ARCADE_ROUND_TIMEOUT_EN
    exp_q.push_back('{hit: 1'b0, miss: 1'b1, score: 4'd0, lives: 2'd2});
    k = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (miss || hit) begin
        k = i;
        break;
      end
    end
    check("timeout_latency", 16'(k), 16'd50);
    // Answer in the last cycle of the window is judged normally.
    wait_ready(ok);
    repeat (49) @(negedge clk);
    answer       = target;
    answer_valid = 1'b1;
    exp_q.push_back('{hit: 1'b1, miss: 1'b0, score: 4'd1, lives: 2'd2});
    @(negedge clk);
    answer_valid = 1'b0;
    @(negedge clk);
`else
    repeat (80) @(negedge clk);
    check("no_timeout_ready", answer_ready, 16'd1);
    check("no_timeout_lives", lives, 16'd3);
    play(1'b1, 4'd1, 2'd3);
`endif
    do_reset();

    // Game 5: reset while waiting with score 4 abandons the round.
    start_pulse();
    for (int r = 1; r <= 4; r++) play(1'b1, 4'(r), 2'd3);
    wait_ready(ok);
    check("pre_rst_score", score, 16'd4);
    #2;
    reset = 1'b0;
    #1;
    check("async_busy",  busy,         16'd0);
    check("async_score", score,        16'd0);
    check("async_ready", answer_ready, 16'd0);
    check("async_pulse", {hit, miss},  16'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", busy, 16'd0);

    // Game 6: start held high -> OVER lasts one cycle, then a fresh game.
    start = 1'b1;
    for (int r = 1; r <= 8; r++) play(1'b1, 4'(r), 2'd3);
    expect_over(4'd8);
    @(negedge clk);
    check("restart_over",  game_over, 16'd0);
    check("restart_busy",  busy,      16'd1);
    check("restart_score", score,     16'd0);
    check("restart_lives", lives,     16'd3);
    start = 1'b0;
    play(1'b0, 4'd0, 2'd2);
    do_reset();

    check("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_arcade_round_ctrl
